// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reconfiguration sequencer:
//   - state_t      : sequencer FSM states
//   - resp_code_t  : completion codes reported on resp_code
//   - DEFAULT_LOCK_TIMEOUT / DEFAULT_SETTLE_CYCLES : parameter defaults
//   - cnt_width()  : counter width able to hold 0..max_count
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  localparam int DEFAULT_LOCK_TIMEOUT  = 65535;
  localparam int DEFAULT_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WAIT_LOCK = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RESP_OK        = 2'd0,
    RESP_BAD_PARAM = 2'd1,
    RESP_TIMEOUT   = 2'd2,
    RESP_SKIPPED   = 2'd3
  } resp_code_t;

  // Bits needed to represent every value 0..max_count (at least 1 bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/pll_seq_timer.sv
// ---------------------------------------------------------------------------
// pll_seq_timer
// Saturating up-counter with synchronous clear and a terminal-count flag.
//
// Parameters:
//   WIDTH : counter width
//   LIMIT : terminal count value
// Ports:
//   clock  : clock
//   reset  : synchronous active-high reset (count -> 0)
//   clear  : synchronous clear (count -> 0), has priority over enable
//   enable : count up by one this cycle (holds at all-ones, never wraps)
//   tc     : high in the cycle whose increment makes the count reach LIMIT,
//            so the caller can act on the same edge the counter gets there
// ---------------------------------------------------------------------------
module pll_seq_timer #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH:0]   LIMIT_EXT = (WIDTH + 1)'(LIMIT);
  localparam logic [WIDTH-1:0] SAT_VALUE = '1;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH:0]   count_inc;

  // One extra bit so the comparison stays correct when LIMIT equals the
  // all-ones value of the counter.
  assign count_inc = {1'b0, count_reg} + (WIDTH + 1)'(1);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != SAT_VALUE)) begin
      count_next = count_inc[WIDTH-1:0];
    end
  end

  assign tc = enable && !clear && (count_inc >= LIMIT_EXT);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reconfig_sequencer
// Accepts {mult, div} reconfiguration requests, validates them, drives the
// PLL reconfiguration interface (pll_data + one-cycle trigger), waits for
// busy to rise and fall, then requires stable_reconfig to hold for
// SETTLE_CYCLES consecutive cycles before reporting OK. A timeout counter
// bounds the whole wait from trigger to settled lock.
//
// Optional feature macro: PLL_SEQ_RETRY_EN
//   defined   : the first timeout of a request re-issues the trigger once;
//               a second timeout responds TIMEOUT.
//   undefined : the first timeout responds TIMEOUT.
//
// Parameters:
//   LOCK_TIMEOUT  : max wait cycles after trigger before TIMEOUT
//   SETTLE_CYCLES : consecutive stable_reconfig cycles required for OK
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   req_mult, req_div       : requested factors
//   pll_data                : {mult, div} held for the PLL interface
//   trigger                 : one-cycle start pulse to the PLL
//   busy, stable_reconfig   : PLL status
//   resp_valid, resp_code   : one-cycle completion pulse and code
//   cur_mult, cur_div       : last successfully applied factors
// ---------------------------------------------------------------------------
module pll_reconfig_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = DEFAULT_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_mult,
  input  logic [7:0]  req_div,
  output logic [15:0] pll_data,
  output logic        trigger,
  input  logic        busy,
  input  logic        stable_reconfig,
  output logic        resp_valid,
  output logic [1:0]  resp_code,
  output logic [7:0]  cur_mult,
  output logic [7:0]  cur_div
);

  localparam int CNT_W = cnt_width(LOCK_TIMEOUT);

  state_t     state_reg, state_next;
  resp_code_t resp_code_reg, resp_code_next;

  logic [7:0]  req_mult_reg, req_div_reg;
  logic [15:0] pll_data_reg;
  logic [7:0]  cur_mult_reg, cur_div_reg;
  logic        cur_valid_reg;

  logic latch_req;
  logic load_pll;
  logic commit_cur;

  logic timeout_clear, timeout_en, timeout_tc;
  logic settle_clear, settle_en, settle_tc;

  logic bad_param;
  logic same_as_cur;

`ifdef PLL_SEQ_RETRY_EN
  logic retry_used_reg;
  logic retry_set;
`endif

  // -------------------------------------------------------------------------
  // Counters
  // -------------------------------------------------------------------------
  assign timeout_clear = (state_reg == ST_ISSUE);
  assign timeout_en    = (state_reg == ST_WAIT_BUSY) ||
                         (state_reg == ST_WAIT_DONE) ||
                         (state_reg == ST_WAIT_LOCK);

  // Any cycle without stable_reconfig (or outside WAIT_LOCK) restarts settling.
  assign settle_en    = (state_reg == ST_WAIT_LOCK) && stable_reconfig;
  assign settle_clear = !settle_en;

  pll_seq_timer #(
    .WIDTH (CNT_W),
    .LIMIT (LOCK_TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (timeout_clear),
    .enable (timeout_en),
    .tc     (timeout_tc)
  );

  pll_seq_timer #(
    .WIDTH (CNT_W),
    .LIMIT (SETTLE_CYCLES)
  ) u_settle (
    .clock  (clock),
    .reset  (reset),
    .clear  (settle_clear),
    .enable (settle_en),
    .tc     (settle_tc)
  );

  // -------------------------------------------------------------------------
  // Request classification (evaluated in CHECK)
  // -------------------------------------------------------------------------
  assign bad_param   = (req_mult_reg == 8'd0) || (req_div_reg == 8'd0);
  assign same_as_cur = cur_valid_reg && stable_reconfig &&
                       (req_mult_reg == cur_mult_reg) &&
                       (req_div_reg == cur_div_reg);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    resp_code_next = resp_code_reg;
    latch_req      = 1'b0;
    load_pll       = 1'b0;
    commit_cur     = 1'b0;
`ifdef PLL_SEQ_RETRY_EN
    retry_set      = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          latch_req  = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_param) begin
          resp_code_next = RESP_BAD_PARAM;
          state_next     = ST_RESP;
        end else if (same_as_cur) begin
          resp_code_next = RESP_SKIPPED;
          state_next     = ST_RESP;
        end else begin
          load_pll   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (busy) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          state_next = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // exit handled by the counter terminal counts below
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Settle completion outranks a timeout landing in the same cycle.
    // settle_tc can only fire in WAIT_LOCK, timeout_tc only in the wait states.
    if (settle_tc) begin
      resp_code_next = RESP_OK;
      commit_cur     = 1'b1;
      state_next     = ST_RESP;
    end else if (timeout_tc) begin
`ifdef PLL_SEQ_RETRY_EN
      if (!retry_used_reg) begin
        retry_set  = 1'b1;
        state_next = ST_ISSUE;
      end else begin
        resp_code_next = RESP_TIMEOUT;
        state_next     = ST_RESP;
      end
`else
      resp_code_next = RESP_TIMEOUT;
      state_next     = ST_RESP;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      req_mult_reg  <= 8'd0;
      req_div_reg   <= 8'd0;
      pll_data_reg  <= 16'h0000;
      resp_code_reg <= RESP_OK;
      cur_mult_reg  <= 8'd0;
      cur_div_reg   <= 8'd0;
      cur_valid_reg <= 1'b0;
    end else begin
      resp_code_reg <= resp_code_next;
      if (latch_req) begin
        req_mult_reg <= req_mult;
        req_div_reg  <= req_div;
      end
      if (load_pll) begin
        pll_data_reg <= {req_mult_reg, req_div_reg};
      end
      if (commit_cur) begin
        cur_mult_reg  <= req_mult_reg;
        cur_div_reg   <= req_div_reg;
        cur_valid_reg <= 1'b1;
      end
    end
  end

`ifdef PLL_SEQ_RETRY_EN
  // One retry per request; re-armed at every accepted request.
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_used_reg <= 1'b0;
    end else if (latch_req) begin
      retry_used_reg <= 1'b0;
    end else if (retry_set) begin
      retry_used_reg <= 1'b1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_ready  = (state_reg == ST_IDLE);
  assign trigger    = (state_reg == ST_ISSUE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_code  = resp_code_reg;
  assign pll_data   = pll_data_reg;
  assign cur_mult   = cur_mult_reg;
  assign cur_div    = cur_div_reg;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_sequencer
// Directed bench for pll_reconfig_sequencer (LOCK_TIMEOUT=100,
// SETTLE_CYCLES=16). Cycle numbering: cyc is the index of the current clock
// cycle; inputs set during a cycle are the values seen in that cycle.
// Honors PLL_SEQ_RETRY_EN for the timeout expectations.
// ---------------------------------------------------------------------------
module tb_pll_reconfig_sequencer;
  import pll_seq_pkg::*;

  localparam int LT = 100;
  localparam int SC = 16;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_mult;
  logic [7:0]  req_div;
  logic [15:0] pll_data;
  logic        trigger;
  logic        busy;
  logic        stable_reconfig;
  logic        resp_valid;
  logic [1:0]  resp_code;
  logic [7:0]  cur_mult;
  logic [7:0]  cur_div;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int trig_cnt = 0;
  int resp_cnt = 0;
  int last_trig_cyc = 0;
  int last_resp_cyc = 0;
  int last_code     = 0;
  int hs_cyc   = 0;
  int trig_cyc = 0;
  int rise_cyc = 0;
  int wl_cyc   = 0;

  pll_reconfig_sequencer #(
    .LOCK_TIMEOUT  (LT),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_mult        (req_mult),
    .req_div         (req_div),
    .pll_data        (pll_data),
    .trigger         (trigger),
    .busy            (busy),
    .stable_reconfig (stable_reconfig),
    .resp_valid      (resp_valid),
    .resp_code       (resp_code),
    .cur_mult        (cur_mult),
    .cur_div         (cur_div)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and log trigger / response activity for that cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (trigger) begin
      trig_cnt++;
      last_trig_cyc = cyc;
    end
    if (resp_valid) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      last_code     = int'(resp_code);
    end
  endtask

  task automatic clear_log();
    trig_cnt = 0;
    resp_cnt = 0;
  endtask

  task automatic handshake(input logic [7:0] m, input logic [7:0] d);
    req_valid = 1'b1;
    req_mult  = m;
    req_div   = d;
    hs_cyc    = cyc;
    tick();
    req_valid = 1'b0;
    $display("req  mult=%0d div=%0d handshake at cycle %0d", m, d, hs_cyc);
  endtask

  task automatic wait_trigger(input int max_cycles);
    int n = 0;
    while (!trigger && n < max_cycles) begin
      tick();
      n++;
    end
    chk("trigger_seen", 32'(trigger), 32'd1);
    trig_cyc = cyc;
  endtask

  task automatic wait_resp(input int max_cycles);
    int n = 0;
    while (!resp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk("resp_seen", 32'(resp_valid), 32'd1);
    $display("resp code=%0d at cycle %0d triggers=%0d", resp_code, cyc, trig_cnt);
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_mult        = 8'd0;
    req_div         = 8'd0;
    busy            = 1'b0;
    stable_reconfig = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_state",     32'(dut.state_reg),   32'(ST_IDLE));
    chk("rst_req_ready", 32'(req_ready),       32'd1);
    chk("rst_trigger",   32'(trigger),         32'd0);
    chk("rst_resp_valid",32'(resp_valid),      32'd0);
    chk("rst_resp_code", 32'(resp_code),       32'd0);
    chk("rst_pll_data",  32'(pll_data),        32'h0000);
    chk("rst_cur_mult",  32'(cur_mult),        32'd0);
    chk("rst_cur_div",   32'(cur_div),         32'd0);
    chk("rst_cur_valid", 32'(dut.cur_valid_reg), 32'd0);
    chk("rst_tmo_cnt",   32'(dut.u_timeout.count_reg), 32'd0);
    chk("rst_set_cnt",   32'(dut.u_settle.count_reg),  32'd0);
    $display("reset checked at cycle %0d", cyc);

    // ---------------- OK: mult=8 div=2 ----------------
    clear_log();
    handshake(8'd8, 8'd2);
    wait_trigger(10);
    chk("ok_trig_lat",  32'(trig_cyc), 32'(hs_cyc + 2));
    chk("ok_pll_data",  32'(pll_data), 32'h0802);
    repeat (3) tick();               // busy high from trigger + 3
    busy = 1'b1;
    repeat (20) tick();              // 20 busy cycles
    busy = 1'b0;
    tick();                          // WAIT_DONE sees busy low
    stable_reconfig = 1'b1;          // rises on entry to WAIT_LOCK
    rise_cyc = cyc;
    wait_resp(200);
    chk("ok_code",      32'(resp_code), 32'(RESP_OK));
    chk("ok_resp_lat",  32'(cyc), 32'(rise_cyc + SC));
    chk("ok_trig_cnt",  32'(trig_cnt), 32'd1);
    chk("ok_cur_mult",  32'(cur_mult), 32'd8);
    chk("ok_cur_div",   32'(cur_div),  32'd2);
    tick();
    chk("ok_resp_pulse",32'(resp_valid), 32'd0);
    chk("ok_ready_back",32'(req_ready),  32'd1);
    chk("ok_resp_cnt",  32'(resp_cnt),   32'd1);

    // ---------------- BAD_PARAM: mult=0 div=4 ----------------
    clear_log();
    handshake(8'd0, 8'd4);
    wait_resp(10);
    chk("bad_code",     32'(resp_code), 32'(RESP_BAD_PARAM));
    chk("bad_lat",      32'(cyc), 32'(hs_cyc + 2));
    chk("bad_no_trig",  32'(trig_cnt), 32'd0);
    chk("bad_pll_data", 32'(pll_data), 32'h0802);
    chk("bad_cur_mult", 32'(cur_mult), 32'd8);
    tick();

    // ---------------- SKIPPED: repeat 8/2 while stable ----------------
    clear_log();
    handshake(8'd8, 8'd2);
    wait_resp(10);
    chk("skip_code",    32'(resp_code), 32'(RESP_SKIPPED));
    chk("skip_lat",     32'(cyc), 32'(hs_cyc + 2));
    chk("skip_no_trig", 32'(trig_cnt), 32'd0);
    tick();

    // ---------------- TIMEOUT: busy never asserts ----------------
    clear_log();
    stable_reconfig = 1'b0;
    handshake(8'd5, 8'd3);
    wait_trigger(10);
    chk("tmo_pll_data", 32'(pll_data), 32'h0503);
    wait_resp(400);
    chk("tmo_code",     32'(resp_code), 32'(RESP_TIMEOUT));
`ifdef PLL_SEQ_RETRY_EN
    chk("tmo_trig_cnt", 32'(trig_cnt), 32'd2);
    chk("tmo_retry_at", 32'(last_trig_cyc), 32'(trig_cyc + LT + 1));
    chk("tmo_lat",      32'(cyc), 32'(trig_cyc + 2 * (LT + 1)));
`else
    chk("tmo_trig_cnt", 32'(trig_cnt), 32'd1);
    chk("tmo_lat",      32'(cyc), 32'(trig_cyc + LT + 1));
`endif
    chk("tmo_cur_mult", 32'(cur_mult), 32'd8);
    chk("tmo_cur_div",  32'(cur_div),  32'd2);
    tick();

    // ---------------- settle glitch at count 10: mult=6 div=1 ----------------
    clear_log();
    handshake(8'd6, 8'd1);
    wait_trigger(10);
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    wl_cyc = cyc;                    // first WAIT_LOCK cycle
    chk("gl_state_lock", 32'(dut.state_reg), 32'(ST_WAIT_LOCK));
    chk("gl_earliest",   32'(wl_cyc), 32'(trig_cyc + 3));
    stable_reconfig = 1'b1;
    repeat (10) tick();
    chk("gl_settle_10",  32'(dut.u_settle.count_reg), 32'd10);
    stable_reconfig = 1'b0;
    tick();
    stable_reconfig = 1'b1;
    wait_resp(100);
    chk("gl_code",      32'(resp_code), 32'(RESP_OK));
    chk("gl_lat",       32'(cyc), 32'(wl_cyc + 11 + SC));
    chk("gl_cur_mult",  32'(cur_mult), 32'd6);
    chk("gl_cur_div",   32'(cur_div),  32'd1);
    tick();

    // ---------------- reset during WAIT_DONE ----------------
    clear_log();
    stable_reconfig = 1'b0;
    handshake(8'd9, 8'd9);
    wait_trigger(10);
    tick();
    busy = 1'b1;
    tick();
    chk("rd_in_wait_done", 32'(dut.state_reg), 32'(ST_WAIT_DONE));
    reset = 1'b1;
    tick();
    chk("rd_state",      32'(dut.state_reg), 32'(ST_IDLE));
    chk("rd_req_ready",  32'(req_ready),     32'd1);
    chk("rd_resp_valid", 32'(resp_valid),    32'd0);
    chk("rd_cur_valid",  32'(dut.cur_valid_reg), 32'd0);
    chk("rd_cur_mult",   32'(cur_mult),      32'd0);
    reset = 1'b0;
    busy  = 1'b0;
    repeat (5) tick();
    chk("rd_no_resp",    32'(resp_cnt),      32'd0);
    chk("rd_pll_data",   32'(pll_data),      32'h0000);
    $display("reset-in-flight checked at cycle %0d", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_sequencer.md
PLL_RECONFIG_SEQUENCER -- requirements
Module: pll_reconfig_sequencer

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 65535: maximum cycles from trigger to settled lock before the request is failed.
REQ-002 Parameter SETTLE_CYCLES, default 16: consecutive cycles stable_reconfig must hold high before the request is declared complete.
REQ-003 clock  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  new reconfiguration request present.
REQ-006 req_ready  output  1  sequencer can accept a request this cycle.
REQ-007 req_mult  input  8  requested multiply factor.
REQ-008 req_div  input  8  requested divide factor.
REQ-009 pll_data  output  16  {mult, div} presented to the PLL reconfiguration interface.
REQ-010 trigger  output  1  one-cycle start pulse to the PLL reconfiguration interface.
REQ-011 busy  input  1  PLL reconfiguration in progress.
REQ-012 stable_reconfig  input  1  PLL locked and reconfiguration controller idle.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_code  output  2  completion code: 0 = OK, 1 = BAD_PARAM, 2 = TIMEOUT, 3 = SKIPPED.
REQ-015 cur_mult, cur_div  output  8 each  last successfully applied factors.

Function
REQ-016 States: IDLE, CHECK, ISSUE, WAIT_BUSY, WAIT_DONE, WAIT_LOCK, RESP.
REQ-017 req_ready shall be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1, which latches req_mult/req_div and moves to CHECK.
REQ-018 CHECK, with req_mult==0 or req_div==0: go to RESP with code BAD_PARAM; no trigger is issued.
REQ-019 CHECK, with the request equal to {cur_mult,cur_div}, cur_valid=1 and stable_reconfig=1: go to RESP with code SKIPPED; no trigger is issued.
REQ-020 CHECK, otherwise: go to ISSUE.
REQ-021 pll_data shall be updated with the latched request on entry to ISSUE and held constant until the next ISSUE.
REQ-022 In ISSUE, trigger shall be 1 for exactly one cycle, the timeout counter shall clear, and the FSM moves to WAIT_BUSY.
REQ-023 WAIT_BUSY: on busy=1, go to WAIT_DONE.
REQ-024 WAIT_DONE: on busy=0, go to WAIT_LOCK.
REQ-025 WAIT_LOCK: the settle counter increments while stable_reconfig=1 and clears to 0 on any cycle where it is 0.
REQ-026 WAIT_LOCK: when the settle counter reaches SETTLE_CYCLES, go to RESP with code OK and update cur_mult/cur_div/cur_valid.
REQ-027 The timeout counter shall increment every cycle in WAIT_BUSY, WAIT_DONE and WAIT_LOCK.
REQ-028 When the timeout counter reaches LOCK_TIMEOUT, go to RESP with code TIMEOUT and leave cur_* unchanged.
REQ-029 If timeout and settle completion occur in the same cycle, OK wins.
REQ-030 RESP asserts resp_valid for exactly one cycle with resp_code valid, then returns to IDLE.
REQ-031 Request-to-resp_valid latency: BAD_PARAM and SKIPPED responses occur 2 cycles after the handshake; the earliest OK occurs at ISSUE + 3 + SETTLE_CYCLES.
REQ-032 Counters shall saturate and never wrap; both counters are sized as clog2(LOCK_TIMEOUT+1) bits.

Reset
REQ-033 Reset applies to every state, at any point in an operation.
REQ-034 Reset values: state=IDLE, req_ready=1 one cycle after reset deasserts, trigger=0, resp_valid=0, resp_code=0, pll_data=16'h0000, cur_mult=0, cur_div=0, cur_valid=0, all counters 0.
REQ-035 A request in flight when reset asserts shall be abandoned with no response.

Configuration
REQ-036 Macro PLL_SEQ_RETRY_EN, when defined: on the first TIMEOUT of a request, the FSM re-enters ISSUE once instead of RESP, producing a second trigger pulse; a second timeout responds TIMEOUT.
REQ-037 When PLL_SEQ_RETRY_EN is undefined, the first timeout responds TIMEOUT and the retry logic is absent.

Structure
REQ-038 Shared package pll_seq_pkg shall hold the state enum, the resp_code enum (RESP_OK, RESP_BAD_PARAM, RESP_TIMEOUT, RESP_SKIPPED) and the default LOCK_TIMEOUT/SETTLE_CYCLES constants.
REQ-039 One sub-module, pll_seq_timer, shall provide a saturating counter with clear/enable/terminal-count, instantiated twice (timeout and settle).

Verification
REQ-040 Request mult=8, div=2; bench asserts busy 3 cycles after trigger for 20 cycles, then stable_reconfig; response is one trigger pulse, pll_data=16'h0802, resp_code=OK SETTLE_CYCLES cycles after stable_reconfig rises, cur_mult=8, cur_div=2.
REQ-041 Request mult=0, div=4 -> resp_code=BAD_PARAM 2 cycles after the handshake, no trigger, pll_data unchanged.
REQ-042 Repeat of mult=8, div=2 with stable_reconfig=1 -> resp_code=SKIPPED, no trigger.
REQ-043 With LOCK_TIMEOUT=100, busy never asserts -> resp_code=TIMEOUT 100 cycles after the trigger; with PLL_SEQ_RETRY_EN, a second trigger occurs and TIMEOUT comes after 200+ cycles.
REQ-044 stable_reconfig drops for 1 cycle at settle count 10 -> the settle count restarts and OK is delayed accordingly.
REQ-045 Reset asserted during WAIT_DONE -> next cycle state=IDLE, req_ready=1, no resp_valid, cur_valid=0.
